// File: rtl/conv_seq_ctrl.sv
// Sequencer for the 3x3 convolution accelerator: loads weights, clears the
// engine, then streams pixels from memory through it and writes results back.
module conv_seq_ctrl #(
  parameter int AW = 16,
  parameter int DW = 32,
  parameter int NW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] w_base,
  input  logic [AW-1:0] px_base,
  input  logic [AW-1:0] res_base,
  input  logic [NW-1:0] npix,
  output logic          busy,
  output logic          done,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_gnt,
  input  logic [DW-1:0] mem_rdata,
  output logic          acc_en,
  output logic          acc_we,
  output logic [3:0]    acc_addr,
  output logic [DW-1:0] acc_din,
  input  logic [DW-1:0] acc_dout
);

  typedef enum logic [3:0] {
    IDLE,
    RD_W,
    WT_W,
    WR_W,
    CLR,
    RD_PX,
    WT_PX,
    WR_PX,
    RD_ACC,
    CAP,
    WR_RES,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic [AW-1:0] w_base_r;
  logic [AW-1:0] px_base_r;
  logic [AW-1:0] res_base_r;
  logic [NW-1:0] npix_r;
  logic [3:0]    j;
  logic [NW-1:0] k;
  logic [DW-1:0] data_r;
  logic          last_pix;

  assign last_pix = (k == (npix_r - NW'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // One data register is shared: weight, pixel and result never overlap in time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_base_r   <= '0;
      px_base_r  <= '0;
      res_base_r <= '0;
      npix_r     <= '0;
      j          <= '0;
      k          <= '0;
      data_r     <= '0;
    end else if (!abort) begin
      case (state)
        IDLE: begin
          if (start) begin
            w_base_r   <= w_base;
            px_base_r  <= px_base;
            res_base_r <= res_base;
            npix_r     <= npix;
            j          <= '0;
            k          <= '0;
          end
        end
        WT_W, WT_PX: data_r <= mem_rdata;
        CAP:         data_r <= acc_dout;
        WR_W: begin
          if (j != 4'd8) begin
            j <= j + 4'd1;
          end
        end
        WR_RES: begin
          if (mem_gnt && !last_pix) begin
            k <= k + NW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    acc_en    = 1'b0;
    acc_we    = 1'b0;
    acc_addr  = 4'd0;
    acc_din   = '0;

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RD_W;
        end
      end
      RD_W: begin
        mem_req  = 1'b1;
        mem_addr = w_base_r + AW'(j);
        if (mem_gnt) begin
          state_nxt = WT_W;
        end
      end
      WT_W: state_nxt = WR_W;
      WR_W: begin
        acc_en    = 1'b1;
        acc_we    = 1'b1;
        acc_addr  = 4'd3 + j;
        acc_din   = data_r;
        state_nxt = (j == 4'd8) ? CLR : RD_W;
      end
      CLR: begin
        acc_en    = 1'b1;
        acc_we    = 1'b1;
        acc_addr  = 4'd2;
        state_nxt = (npix_r == '0) ? DONE : RD_PX;
      end
      RD_PX: begin
        mem_req  = 1'b1;
        mem_addr = px_base_r + AW'(k);
        if (mem_gnt) begin
          state_nxt = WT_PX;
        end
      end
      WT_PX: state_nxt = WR_PX;
      WR_PX: begin
        acc_en    = 1'b1;
        acc_we    = 1'b1;
        acc_addr  = 4'd0;
        acc_din   = data_r;
        state_nxt = RD_ACC;
      end
      RD_ACC: begin
        acc_en    = 1'b1;
        acc_addr  = 4'd1;
        state_nxt = CAP;
      end
      CAP: state_nxt = WR_RES;
      WR_RES: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = res_base_r + AW'(k);
        mem_wdata = data_r;
        if (mem_gnt) begin
          state_nxt = last_pix ? DONE : RD_PX;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // Abort overrides every transition, including a start seen in IDLE.
    if (abort) begin
      state_nxt = IDLE;
    end
  end

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Bench for conv_seq_ctrl: behavioural memory and accelerator models, random
// grant stalls, and a transaction-level reference built from the job config.
module tb_conv_seq_ctrl;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int NW = 16;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b1;
  logic          start    = 1'b0;
  logic          abort    = 1'b0;
  logic [AW-1:0] w_base   = '0;
  logic [AW-1:0] px_base  = '0;
  logic [AW-1:0] res_base = '0;
  logic [NW-1:0] npix     = '0;
  logic          busy;
  logic          done;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_gnt  = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          acc_en;
  logic          acc_we;
  logic [3:0]    acc_addr;
  logic [DW-1:0] acc_din;
  logic [DW-1:0] acc_dout = '0;

  int compared   = 0;
  int mismatched = 0;

  conv_seq_ctrl #(.AW(AW), .DW(DW), .NW(NW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .w_base    (w_base),
    .px_base   (px_base),
    .res_base  (res_base),
    .npix      (npix),
    .busy      (busy),
    .done      (done),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_gnt   (mem_gnt),
    .mem_rdata (mem_rdata),
    .acc_en    (acc_en),
    .acc_we    (acc_we),
    .acc_addr  (acc_addr),
    .acc_din   (acc_din),
    .acc_dout  (acc_dout)
  );

  always #5 clk = ~clk;

  logic [DW-1:0]      mem [0:65535];
  logic [AW-1:0]      rd_q[$];
  logic [AW+DW-1:0]   wr_q[$];
  logic [4+DW-1:0]    accw_q[$];
  int                 acc_rd_cnt = 0;
  int                 gnt_mode   = 0;
  int                 wait_total = 0;
  int                 stab_err   = 0;

  // Grant policy: 0 immediate, 1 three stalls, 2 random 0..3 stalls, 3 never grant writes.
  int wait_left = 0;
  bit in_req    = 1'b0;
  always @(negedge clk) begin
    if (mem_req && (!in_req || mem_gnt)) begin
      case (gnt_mode)
        1:       wait_left = 3;
        2:       wait_left = int'($urandom_range(3, 0));
        default: wait_left = 0;
      endcase
      wait_total += wait_left;
    end
    in_req = mem_req;
    if (!mem_req) begin
      mem_gnt = 1'b0;
    end else if (gnt_mode == 3 && mem_we) begin
      mem_gnt = 1'b0;
    end else if (wait_left == 0) begin
      mem_gnt = 1'b1;
    end else begin
      mem_gnt = 1'b0;
      wait_left--;
    end
  end

  // Memory and accelerator models; reads return noise except in the valid cycle.
  logic [DW-1:0]        acc_w [0:8];
  logic [DW-1:0]        acc_res = '0;
  int                   acc_cnt = 0;
  bit                   stall_pending = 1'b0;
  logic [AW+DW:0]       stall_snap = '0;
  always @(posedge clk) begin
    if (stall_pending && mem_req) begin
      if ({mem_addr, mem_we, mem_wdata} !== stall_snap) begin
        stab_err++;
      end
    end
    stall_pending = mem_req && !mem_gnt;
    stall_snap    = {mem_addr, mem_we, mem_wdata};

    if (mem_req && mem_gnt && !mem_we) begin
      rd_q.push_back(mem_addr);
      mem_rdata <= mem[mem_addr];
    end else begin
      if (mem_req && mem_gnt) begin
        wr_q.push_back({mem_addr, mem_wdata});
      end
      mem_rdata <= $urandom;
    end

    if (acc_en && acc_we) begin
      accw_q.push_back({acc_addr, acc_din});
      if (acc_addr >= 4'd3 && acc_addr <= 4'd11) begin
        acc_w[int'(acc_addr) - 3] = acc_din;
      end else if (acc_addr == 4'd2) begin
        acc_cnt = 0;
      end else if (acc_addr == 4'd0) begin
        acc_res = weightSum() * acc_din + DW'(acc_cnt);
        acc_cnt++;
      end
    end
    if (acc_en && !acc_we && acc_addr == 4'd1) begin
      acc_rd_cnt++;
      acc_dout <= acc_res;
    end else begin
      acc_dout <= $urandom;
    end
  end

  function automatic logic [DW-1:0] weightSum();
    logic [DW-1:0] s = '0;
    for (int i = 0; i < 9; i++) s = s + acc_w[i];
    return s;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [AW-1:0] wb, input logic [AW-1:0] pb,
                               input logic [AW-1:0] rb, input logic [NW-1:0] n,
                               input bit poke, output int cycles);
    @(negedge clk);
    w_base = wb; px_base = pb; res_base = rb; npix = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    w_base = AW'($urandom); px_base = AW'($urandom); res_base = AW'($urandom); npix = NW'($urandom);
    cycles = 1;
    checkOutput("busy_after_start", 64'(busy), 64'(1));
    while (!done && cycles < 5000) begin
      @(negedge clk);
      cycles++;
      start = (poke && cycles == 40);
    end
    start = 1'b0;
    checkOutput("done_seen", 64'(done), 64'(1));
  endtask

  // Reference: expected traffic derived directly from the job configuration.
  task automatic checkJob(input string tag, input logic [AW-1:0] wb, input logic [AW-1:0] pb,
                          input logic [AW-1:0] rb, input int n,
                          input int rd0, input int wr0, input int aw0, input int ar0);
    logic [DW-1:0]    wsum = '0;
    logic [AW-1:0]    a;
    logic [4+DW-1:0]  e;
    logic [AW+DW-1:0] w;
    for (int i = 0; i < 9; i++) wsum = wsum + mem[wb + AW'(i)];
    checkOutput($sformatf("%s acc_wr_count", tag), 64'(accw_q.size() - aw0), 64'(10 + n));
    checkOutput($sformatf("%s mem_rd_count", tag), 64'(rd_q.size() - rd0), 64'(9 + n));
    checkOutput($sformatf("%s mem_wr_count", tag), 64'(wr_q.size() - wr0), 64'(n));
    checkOutput($sformatf("%s acc_rd_count", tag), 64'(acc_rd_cnt - ar0), 64'(n));
    for (int i = 0; i < 9; i++) begin
      a = wb + AW'(i);
      if (rd0 + i < rd_q.size())
        checkOutput($sformatf("%s w_rd%0d", tag, i), 64'(rd_q[rd0 + i]), 64'(a));
      if (aw0 + i < accw_q.size()) begin
        e = accw_q[aw0 + i];
        checkOutput($sformatf("%s w_acc%0d", tag, i), 64'(e), 64'({4'(3 + i), mem[a]}));
      end
    end
    if (aw0 + 9 < accw_q.size()) begin
      e = accw_q[aw0 + 9];
      checkOutput($sformatf("%s clr_addr", tag), 64'(e[DW+3:DW]), 64'(2));
    end
    for (int p = 0; p < n; p++) begin
      a = pb + AW'(p);
      if (rd0 + 9 + p < rd_q.size())
        checkOutput($sformatf("%s px_rd%0d", tag, p), 64'(rd_q[rd0 + 9 + p]), 64'(a));
      if (aw0 + 10 + p < accw_q.size())
        checkOutput($sformatf("%s px_acc%0d", tag, p), 64'(accw_q[aw0 + 10 + p]), 64'({4'd0, mem[a]}));
      if (wr0 + p < wr_q.size()) begin
        w = wr_q[wr0 + p];
        checkOutput($sformatf("%s res%0d", tag, p), 64'(w),
                    64'({rb + AW'(p), wsum * mem[a] + DW'(p)}));
      end
    end
  endtask

  task automatic runJob(input string tag, input logic [AW-1:0] wb, input logic [AW-1:0] pb,
                        input logic [AW-1:0] rb, input logic [NW-1:0] n,
                        input int mode, input bit poke);
    int rd0 = rd_q.size();
    int wr0 = wr_q.size();
    int aw0 = accw_q.size();
    int ar0 = acc_rd_cnt;
    int s0  = stab_err;
    int w0  = wait_total;
    int cycles;
    gnt_mode = mode;
    applyStimulus(wb, pb, rb, n, poke, cycles);
    checkOutput($sformatf("%s done_cycle", tag), 64'(cycles), 64'(29 + 6 * int'(n) + wait_total - w0));
    @(negedge clk);
    checkOutput($sformatf("%s done_pulse", tag), 64'(done), 64'(0));
    checkOutput($sformatf("%s busy_after", tag), 64'(busy), 64'(0));
    checkOutput($sformatf("%s mem_stable", tag), 64'(stab_err - s0), 64'(0));
    checkJob(tag, wb, pb, rb, int'(n), rd0, wr0, aw0, ar0);
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, " busy"}, 64'(busy), 64'(0));
    checkOutput({tag, " done"}, 64'(done), 64'(0));
    checkOutput({tag, " mem_bus"}, 64'({mem_req, mem_we, mem_addr, mem_wdata}), 64'(0));
    checkOutput({tag, " acc_bus"}, 64'({acc_en, acc_we, acc_addr, acc_din}), 64'(0));
  endtask

  initial begin
    int cyc;
    int wr0;
    int dcnt;
    for (int i = 0; i < 65536; i++) mem[i] = $urandom;
    for (int i = 0; i < 9; i++) acc_w[i] = '0;

    #3 rst_n = 1'b0;
    #1 checkQuiet("reset");
    @(negedge clk); @(negedge clk);
    #2 rst_n = 1'b1;

    // Abort together with start in IDLE must leave the block idle.
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    checkQuiet("abort_start_idle");
    @(negedge clk);
    checkOutput("abort_start_idle later", 64'(busy), 64'(0));

    // Weights 1..9 at 0x10 with no pixels.
    for (int i = 0; i < 9; i++) mem[16'h0010 + i] = DW'(i + 1);
    runJob("npix0", 16'h0010, 16'h0100, 16'h0200, 16'd0, 0, 1'b0);

    // 8x8 image of ones with unit weights; a stray start mid-run must be ignored.
    for (int i = 0; i < 9; i++) mem[16'h0040 + i] = 32'd1;
    for (int i = 0; i < 64; i++) mem[16'h0100 + i] = 32'd1;
    runJob("img64", 16'h0040, 16'h0100, 16'h0200, 16'd64, 0, 1'b1);
    runJob("img64_stall3", 16'h0040, 16'h0100, 16'h0200, 16'd64, 1, 1'b0);

    runJob("rand_a", AW'($urandom), AW'($urandom), AW'($urandom), NW'($urandom_range(8, 1)), 2, 1'b0);
    runJob("wrap", 16'hFFFC, 16'hFFFE, 16'hFFFD, 16'd5, 2, 1'b1);
    runJob("single", AW'($urandom), AW'($urandom), AW'($urandom), 16'd1, 0, 1'b0);

    // Reset while pixel 5 is in flight, then a clean rerun.
    gnt_mode = 0;
    cyc = 0;
    @(negedge clk);
    w_base = 16'h0300; px_base = 16'h0400; res_base = 16'h0500; npix = 16'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wr0 = rd_q.size();
    while (rd_q.size() < wr0 + 15 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("midreset reached px5", 64'(rd_q.size() - wr0), 64'(15));
    #2 rst_n = 1'b0;
    #1 checkQuiet("midreset");
    @(negedge clk);
    #2 rst_n = 1'b1;
    runJob("after_reset", 16'h0300, 16'h0400, 16'h0500, 16'd10, 2, 1'b0);

    // Abort while a result write waits for a grant that never comes.
    gnt_mode = 3;
    wr0 = wr_q.size();
    cyc = 0;
    @(negedge clk);
    w_base = AW'($urandom); px_base = AW'($urandom); res_base = AW'($urandom); npix = 16'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!(mem_req && mem_we) && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("abort reached WR_RES", 64'(mem_req && mem_we), 64'(1));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkQuiet("abort");
    dcnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    checkOutput("abort no done", 64'(dcnt), 64'(0));
    checkOutput("abort no write", 64'(wr_q.size() - wr0), 64'(0));
    runJob("after_abort", AW'($urandom), AW'($urandom), AW'($urandom), 16'd2, 2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
